// File: rtl/bambu_mem_pkg.sv
// Shared types and helpers for the off-chip memory slave: channel FSM states,
// write-mask decoding and address-window test.
package bambu_mem_pkg;

  localparam int NUM_CH = 2;
  localparam int BYTE_W = 8;
  localparam int SIZE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } chan_state_e;

  // Bit count to byte-lane mask: 0 -> none, 1..7 -> low bits, 8+ -> full byte.
  function automatic logic [7:0] size_to_mask(input logic [3:0] size);
    logic [7:0] m;
    if (size >= 4'd8) m = 8'hFF;
    else              m = 8'((9'd1 << size) - 9'd1);
    return m;
  endfunction

  function automatic logic in_window(input logic [31:0] addr,
                                     input int unsigned base,
                                     input int unsigned size);
    return (addr >= base) && (addr < base + size);
  endfunction

endpackage

// File: rtl/bambu_mem_chan_ctrl.sv
// One bus channel: accepts a read or write in IDLE, counts out the programmed
// latency and emits a one-cycle DataRdy pulse with the read byte.
module bambu_mem_chan_ctrl
  import bambu_mem_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int MEMSIZE   = 64,
  parameter int BASE_ADDR = 0,
  parameter int RD_DELAY  = 2,
  parameter int WR_DELAY  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              oe_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        rd_byte_i,
  output logic              wr_accept_o,
  output logic              dual_req_o,
  output logic [7:0]        rdata_o,
  output logic              data_rdy_o
);

  localparam int MAX_DELAY = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_DELAY);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_DELAY);

  chan_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [7:0]       data_q;
  logic [7:0]       rdata_q;
  logic             rdy_q;

  logic idle;
  logic hit;
  logic rd_accept;
  logic wr_accept;

  // Handshake: the master raises oe or we and holds it until it sees DataRdy;
  // only IDLE accepts, so a held request is one transaction, and the earliest
  // next acceptance is the edge after the DataRdy cycle.
  assign idle      = (state_q == IDLE);
  assign hit       = in_window(32'(addr_i), BASE_ADDR, MEMSIZE);
  assign rd_accept = idle & hit & oe_i & ~we_i & ~rst_i;
  assign wr_accept = idle & hit & we_i & ~oe_i & ~rst_i;
  assign cnt_d     = cnt_q + 1'b1;

  assign wr_accept_o = wr_accept;
  assign dual_req_o  = idle & oe_i & we_i;
  assign rdata_o     = rdata_q;
  assign data_rdy_o  = rdy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (rd_accept) begin
            data_q  <= rd_byte_i;
            state_q <= RD_WAIT;
            cnt_q   <= CNT_W'(1);
          end else if (wr_accept) begin
            state_q <= WR_WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        RD_WAIT: begin
          if (cnt_q == RD_LAST) begin
            rdy_q   <= 1'b1;
            rdata_q <= data_q;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WR_WAIT: begin
          if (cnt_q == WR_LAST) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bambu_ext_mem_slave.sv
// Two-channel byte memory slave for the HLS Mout_* bus: owns the byte array,
// write arbitration (ch1 over ch0, preload over both) and the sticky error flag.
module bambu_ext_mem_slave
  import bambu_mem_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int MEMSIZE   = 64,
  parameter int BASE_ADDR = 0,
  parameter int RD_DELAY  = 2,
  parameter int WR_DELAY  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          Mout_oe_ram,
  input  logic [NUM_CH-1:0]          Mout_we_ram,
  input  logic [NUM_CH*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [NUM_CH*BYTE_W-1:0]   Mout_Wdata_ram,
  input  logic [NUM_CH*SIZE_W-1:0]   Mout_data_ram_size,
  input  logic                       load_en,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic [7:0]                 load_data,
  output logic [NUM_CH*BYTE_W-1:0]   M_Rdata_ram,
  output logic [NUM_CH-1:0]          M_DataRdy,
  output logic                       proto_err
);

  localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  logic [7:0]       mem_q [MEMSIZE];
  logic [IDX_W-1:0] idx     [NUM_CH];
  logic [7:0]       rd_byte [NUM_CH];
  logic [7:0]       wmask   [NUM_CH];
  logic [7:0]       wdata   [NUM_CH];
  logic [NUM_CH-1:0] wr_acc;
  logic [NUM_CH-1:0] dual_req;

  logic             load_in_range;
  logic             load_commit;
  logic [IDX_W-1:0] load_idx;
  logic             proto_err_q;
  logic             proto_err_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign idx[c]     = IDX_W'(Mout_addr_ram[c*ADDR_W +: ADDR_W] - ADDR_W'(BASE_ADDR));
    assign rd_byte[c] = mem_q[idx[c]];
    assign wmask[c]   = size_to_mask(Mout_data_ram_size[c*SIZE_W +: SIZE_W]);
    assign wdata[c]   = Mout_Wdata_ram[c*BYTE_W +: BYTE_W];

    bambu_mem_chan_ctrl #(
      .ADDR_W   (ADDR_W),
      .MEMSIZE  (MEMSIZE),
      .BASE_ADDR(BASE_ADDR),
      .RD_DELAY (RD_DELAY),
      .WR_DELAY (WR_DELAY)
    ) u_chan (
      .clk_i      (clock),
      .rst_i      (reset),
      .oe_i       (Mout_oe_ram[c]),
      .we_i       (Mout_we_ram[c]),
      .addr_i     (Mout_addr_ram[c*ADDR_W +: ADDR_W]),
      .rd_byte_i  (rd_byte[c]),
      .wr_accept_o(wr_acc[c]),
      .dual_req_o (dual_req[c]),
      .rdata_o    (M_Rdata_ram[c*BYTE_W +: BYTE_W]),
      .data_rdy_o (M_DataRdy[c])
    );
  end

  assign load_in_range = (32'(load_addr) < 32'(MEMSIZE));
  assign load_commit   = load_en & load_in_range;
  assign load_idx      = IDX_W'(load_addr);

  // Later non-blocking writes win: ch1 over ch0, preload over both.
  // Reads sample mem_q before this edge, so a same-cycle read sees the old byte.
  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_acc[c]) begin
        mem_q[idx[c]] <= (wdata[c] & wmask[c]) | (mem_q[idx[c]] & ~wmask[c]);
      end
    end
    if (load_commit) begin
      mem_q[load_idx] <= load_data;
    end
  end

  assign proto_err_d = proto_err_q | (|dual_req) |
                       (load_en & ~load_in_range) | (load_en & (|wr_acc));

  always_ff @(posedge clock) begin
    if (reset) proto_err_q <= 1'b0;
    else       proto_err_q <= proto_err_d;
  end

  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_bambu_ext_mem_slave.sv
// Directed bench for bambu_ext_mem_slave: default-latency instance plus a
// RD_DELAY=4 instance sharing the same stimulus.
module tb_bambu_ext_mem_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  oe;
  logic [1:0]  we;
  logic [13:0] addr;
  logic [15:0] wdata;
  logic [7:0]  size;
  logic        load_en;
  logic [6:0]  load_addr;
  logic [7:0]  load_data;

  logic [15:0] rdata, rdata4;
  logic [1:0]  rdy, rdy4;
  logic        perr, perr4;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bambu_ext_mem_slave dut (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .M_Rdata_ram(rdata), .M_DataRdy(rdy), .proto_err(perr)
  );

  bambu_ext_mem_slave #(.RD_DELAY(4)) dut4 (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .M_Rdata_ram(rdata4), .M_DataRdy(rdy4), .proto_err(perr4)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic is_wr, input logic [6:0] a,
                         input logic [7:0] d, input logic [3:0] sz);
    addr[ch*7 +: 7]  = a;
    wdata[ch*8 +: 8] = d;
    size[ch*4 +: 4]  = sz;
    if (is_wr) we[ch] = 1'b1;
    else       oe[ch] = 1'b1;
  endtask

  // Holds the request until DataRdy (bounded); lat counts edges from issue.
  task automatic do_xfer(input int ch, input logic is_wr, input logic [6:0] a,
                         input logic [7:0] d, input logic [3:0] sz,
                         output int lat, output logic [7:0] rd);
    set_req(ch, is_wr, a, d, sz);
    lat = 99;
    rd  = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rdy[ch]) begin
        lat = k;
        rd  = rdata[ch*8 +: 8];
        break;
      end
    end
    oe[ch] = 1'b0;
    we[ch] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (rdy !== 2'b00) begin failures++; $display("FAIL reset_rdy got=%b exp=00", rdy); end
    checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    checks++; if (perr !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", perr); end
    checks++; if ({rdy4, rdata4, perr4} !== 19'h0) begin failures++; $display("FAIL reset_dut4 got=%h exp=0", {rdy4, rdata4, perr4}); end
  endtask

  task automatic test_read();
    logic [1:0]  exp_rdy;
    logic [15:0] exp_rd;
    preload(7'd5, 8'hA5);
    set_req(0, 1'b0, 7'd5, 8'h00, 4'd8);
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_rdy = (k == 3) ? 2'b01 : 2'b00;
      exp_rd  = (k == 3) ? 16'h00A5 : 16'h0000;
      checks++; if (rdy !== exp_rdy) begin failures++; $display("FAIL read_rdy k=%0d got=%b exp=%b", k, rdy, exp_rdy); end
      checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL read_data k=%0d got=%h exp=%h", k, rdata, exp_rd); end
      if (k == 3) oe[0] = 1'b0;
    end
  endtask

  task automatic test_write_mask();
    logic [1:0] exp_rdy;
    int lat;
    logic [7:0] rd;
    set_req(1, 1'b1, 7'd9, 8'h3C, 4'd8);
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_rdy = (k == 2) ? 2'b10 : 2'b00;
      checks++; if (rdy !== exp_rdy) begin failures++; $display("FAIL write_rdy k=%0d got=%b exp=%b", k, rdy, exp_rdy); end
      checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL write_rdata k=%0d got=%h exp=0000", k, rdata); end
      if (k == 2) we[1] = 1'b0;
    end
    do_xfer(1, 1'b0, 7'd9, 8'h00, 4'd8, lat, rd);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd9_lat got=%0d exp=3", lat); end
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL rd9_a got=%h exp=3c", rd); end
    do_xfer(1, 1'b1, 7'd9, 8'hFF, 4'd4, lat, rd);
    checks++; if (lat !== 2) begin failures++; $display("FAIL wr9_lat got=%0d exp=2", lat); end
    do_xfer(1, 1'b0, 7'd9, 8'h00, 4'd8, lat, rd);
    checks++; if (rd !== 8'h3F) begin failures++; $display("FAIL mask_size4 got=%h exp=3f", rd); end
    do_xfer(0, 1'b1, 7'd9, 8'h00, 4'd0, lat, rd);
    do_xfer(0, 1'b0, 7'd9, 8'h00, 4'd8, lat, rd);
    checks++; if (rd !== 8'h3F) begin failures++; $display("FAIL mask_size0 got=%h exp=3f", rd); end
    do_xfer(0, 1'b1, 7'd9, 8'h00, 4'd3, lat, rd);
    do_xfer(0, 1'b0, 7'd9, 8'h00, 4'd8, lat, rd);
    checks++; if (rd !== 8'h38) begin failures++; $display("FAIL mask_size3 got=%h exp=38", rd); end
    do_xfer(0, 1'b1, 7'd9, 8'hC0, 4'd15, lat, rd);
    do_xfer(0, 1'b0, 7'd9, 8'h00, 4'd8, lat, rd);
    checks++; if (rd !== 8'hC0) begin failures++; $display("FAIL mask_size15 got=%h exp=c0", rd); end
  endtask

  task automatic test_window();
    int lat;
    logic [7:0] rd;
    set_req(0, 1'b0, 7'd70, 8'h00, 4'd8);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++; if ({rdy, rdata} !== 18'h0) begin failures++; $display("FAIL oob70 k=%0d got=%h exp=0", k, {rdy, rdata}); end
    end
    oe[0] = 1'b0;
    checks++; if (perr !== 1'b0) begin failures++; $display("FAIL oob_perr got=%b exp=0", perr); end
    preload(7'd63, 8'h5A);
    do_xfer(0, 1'b0, 7'd63, 8'h00, 4'd8, lat, rd);
    checks++; if (lat !== 3 || rd !== 8'h5A) begin failures++; $display("FAIL edge63 got=lat%0d/%h exp=lat3/5a", lat, rd); end
    set_req(0, 1'b0, 7'd64, 8'h00, 4'd8);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (rdy !== 2'b00) begin failures++; $display("FAIL oob64 k=%0d got=%b exp=00", k, rdy); end
    end
    oe[0] = 1'b0;
  endtask

  task automatic test_simultaneous();
    int lat;
    logic [7:0] rd;
    set_req(0, 1'b1, 7'd3, 8'h11, 4'd8);
    set_req(1, 1'b1, 7'd3, 8'h22, 4'd8);
    tick();
    tick();
    checks++; if (rdy !== 2'b11) begin failures++; $display("FAIL dual_wr_rdy got=%b exp=11", rdy); end
    we = 2'b00;
    do_xfer(0, 1'b0, 7'd3, 8'h00, 4'd8, lat, rd);
    checks++; if (rd !== 8'h22) begin failures++; $display("FAIL ch1_wins got=%h exp=22", rd); end
    set_req(0, 1'b0, 7'd3, 8'h00, 4'd8);
    set_req(1, 1'b1, 7'd3, 8'h33, 4'd8);
    tick();
    tick();
    checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL rw_wr_rdy got=%b exp=10", rdy); end
    we[1] = 1'b0;
    tick();
    checks++; if (rdy !== 2'b01 || rdata[7:0] !== 8'h22) begin failures++; $display("FAIL rw_old_byte got=%b/%h exp=01/22", rdy, rdata[7:0]); end
    oe[0] = 1'b0;
    do_xfer(0, 1'b0, 7'd3, 8'h00, 4'd8, lat, rd);
    checks++; if (rd !== 8'h33) begin failures++; $display("FAIL rw_new_byte got=%h exp=33", rd); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] rd;
    do_xfer(0, 1'b0, 7'd5, 8'h00, 4'd8, lat, rd);
    checks++; if (lat !== 3 || rd !== 8'hA5) begin failures++; $display("FAIL b2b_rd1 got=lat%0d/%h exp=lat3/a5", lat, rd); end
    do_xfer(0, 1'b0, 7'd9, 8'h00, 4'd8, lat, rd);
    checks++; if (lat !== 3 || rd !== 8'hC0) begin failures++; $display("FAIL b2b_rd2 got=lat%0d/%h exp=lat3/c0", lat, rd); end
    do_xfer(1, 1'b1, 7'd10, 8'h5E, 4'd8, lat, rd);
    checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_wr got=lat%0d exp=lat2", lat); end
    do_xfer(1, 1'b0, 7'd10, 8'h00, 4'd8, lat, rd);
    checks++; if (lat !== 3 || rd !== 8'h5E) begin failures++; $display("FAIL b2b_rd3 got=lat%0d/%h exp=lat3/5e", lat, rd); end
  endtask

  task automatic test_proto_err();
    int lat;
    logic [7:0] rd;
    oe[0] = 1'b1; we[0] = 1'b1; addr[6:0] = 7'd5;
    tick();
    checks++; if (perr !== 1'b1) begin failures++; $display("FAIL oe_we_perr got=%b exp=1", perr); end
    oe[0] = 1'b0; we[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if ({perr, rdy} !== 3'b100) begin failures++; $display("FAIL oe_we_sticky k=%0d got=%b exp=100", k, {perr, rdy}); end
    end
    do_reset();
    checks++; if (perr !== 1'b0) begin failures++; $display("FAIL perr_clear got=%b exp=0", perr); end
    preload(7'd30, 8'h44);
    checks++; if (perr !== 1'b0) begin failures++; $display("FAIL load_ok_perr got=%b exp=0", perr); end
    preload(7'd64, 8'h12);
    checks++; if (perr !== 1'b1) begin failures++; $display("FAIL load_oob_perr got=%b exp=1", perr); end
    do_reset();
    set_req(0, 1'b1, 7'd20, 8'h77, 4'd8);
    set_req(1, 1'b1, 7'd21, 8'h99, 4'd8);
    load_en = 1'b1; load_addr = 7'd20; load_data = 8'h88;
    tick();
    load_en = 1'b0;
    checks++; if (perr !== 1'b1) begin failures++; $display("FAIL load_wr_perr got=%b exp=1", perr); end
    tick();
    checks++; if (rdy !== 2'b11) begin failures++; $display("FAIL load_wr_rdy got=%b exp=11", rdy); end
    we = 2'b00;
    do_xfer(0, 1'b0, 7'd20, 8'h00, 4'd8, lat, rd);
    checks++; if (rd !== 8'h88) begin failures++; $display("FAIL load_wins got=%h exp=88", rd); end
    do_xfer(0, 1'b0, 7'd21, 8'h00, 4'd8, lat, rd);
    checks++; if (rd !== 8'h99) begin failures++; $display("FAIL other_wr_commits got=%h exp=99", rd); end
    do_xfer(0, 1'b0, 7'd30, 8'h00, 4'd8, lat, rd);
    checks++; if (rd !== 8'h44) begin failures++; $display("FAIL load30 got=%h exp=44", rd); end
  endtask

  task automatic test_reset_abort();
    logic [1:0]  exp_rdy;
    logic [15:0] exp_rd;
    do_reset();
    set_req(0, 1'b0, 7'd5, 8'h00, 4'd8);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({rdy4, rdata4, perr4} !== 19'h0) begin failures++; $display("FAIL abort_dut4 got=%h exp=0", {rdy4, rdata4, perr4}); end
    checks++; if ({rdy, rdata, perr} !== 19'h0) begin failures++; $display("FAIL abort_dut got=%h exp=0", {rdy, rdata, perr}); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_rdy = (k == 5) ? 2'b01 : 2'b00;
      exp_rd  = (k == 5) ? 16'h00A5 : 16'h0000;
      checks++; if (rdy4 !== exp_rdy) begin failures++; $display("FAIL abort_rdy4 k=%0d got=%b exp=%b", k, rdy4, exp_rdy); end
      checks++; if (rdata4 !== exp_rd) begin failures++; $display("FAIL abort_data4 k=%0d got=%h exp=%h", k, rdata4, exp_rd); end
      if (k == 5) oe[0] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    test_reset();
    test_read();
    test_write_mask();
    test_window();
    test_simultaneous();
    test_back_to_back();
    test_proto_err();
    test_reset_abort();
    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
